// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the raster timing generator (640x480@60 defaults).
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 16;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } vga_sync_t;

  // Sync pins are active low, so idle is both high with nothing visible.
  localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } vga_state_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster outputs consumed by sprite/palette display blocks.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] DrawX;
  logic [COORD_W-1:0] DrawY;
  logic               blank;
  logic               blank_d;
  logic               hs;
  logic               vs;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, blank_d, hs, vs, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Shift register aligning hs/vs/blank with RGB registered downstream; depth 0 is a wire.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  vga_sync_t d_i,
  output vga_sync_t q_o
);

  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_pipe
    vga_sync_t pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= SYNC_IDLE;
      end else begin
        pipe_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter producing DrawX/DrawY/blank plus delayed hs/vs/blank_d sync outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
  parameter int unsigned OUT_DELAY = 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  vga_timing_gen_if.master   vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || OUT_DELAY > 4) begin : g_param_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and OUT_DELAY <= 4");
  end

  // One extra bit so a sync window ending exactly at 1024 still compares correctly.
  localparam int unsigned CW = COORD_W + 1;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  vga_state_e         state_q, state_d;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [CW-1:0] h_ext, v_ext;
  logic          running;
  logic          blank, hs_raw, vs_raw;
  vga_sync_t     sync_raw, sync_dly;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (h_ext == H_LAST) begin
          h_cnt_d = '0;
          if (v_ext == V_LAST) begin
            v_cnt_d     = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign h_ext   = {1'b0, h_cnt_q};
  assign v_ext   = {1'b0, v_cnt_q};
  assign running = (state_q == ST_RUN);

  assign blank  = running && (h_ext < H_VIS) && (v_ext < V_VIS);
  assign hs_raw = !(running && (h_ext >= HS_BEG) && (h_ext < HS_END));
  assign vs_raw = !(running && (v_ext >= VS_BEG) && (v_ext < VS_END));

  assign sync_raw.hs    = hs_raw;
  assign sync_raw.vs    = vs_raw;
  assign sync_raw.blank = blank;

  vga_sync_delay #(
    .DEPTH (OUT_DELAY)
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    (sync_raw),
    .q_o    (sync_dly)
  );

  assign vga.DrawX       = running ? h_cnt_q : '0;
  assign vga.DrawY       = running ? v_cnt_q : '0;
  assign vga.blank       = blank;
  assign vga.line_start  = running && (h_cnt_q == '0);
  assign vga.frame_start = running && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign vga.hs          = sync_dly.hs;
  assign vga.vs          = sync_dly.vs;
  assign vga.blank_d     = sync_dly.blank;
  assign vga.frame_count = frame_cnt_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing that all sprite and palette display blocks consume: DrawX, DrawY, blank, plus the physical hs/vs sync pins.
- Runs on the pixel clock. Defaults give 640x480@60 Hz (25.175 MHz clock).
- Display blocks register their RGB one cycle after reading DrawX/DrawY/blank. This block therefore delays hs/vs, and a copy of blank, by OUT_DELAY cycles so sync stays aligned with the registered RGB.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- OUT_DELAY, 1, pipeline depth applied to hs, vs and blank_d (0..4)

Ports:
- vga_clk  input  1  pixel clock; all state on posedge
- reset_n  input  1  asynchronous active-low reset
- DrawX  output  10  current column; counts 0..H_TOTAL-1
- DrawY  output  10  current row; counts 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), aligned with DrawX/DrawY
- blank_d  output  1  blank delayed by OUT_DELAY cycles
- hs  output  1  horizontal sync, active low, delayed by OUT_DELAY
- vs  output  1  vertical sync, active low, delayed by OUT_DELAY
- line_start  output  1  one-cycle pulse while DrawX==0
- frame_start  output  1  one-cycle pulse while DrawX==0 and DrawY==0
- frame_count  output  16  completed-frame counter; wraps at 65535->0

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters (800). V_TOTAL = sum of the four V_* parameters (525).
- Reset (reset_n=0, asynchronous):
  - h_cnt=0, v_cnt=0, frame_count=0, running=0.
  - Delay pipeline cleared to idle: hs=1, vs=1, blank_d=0.
- While running=0 all outputs are forced idle: DrawX=0, DrawY=0, blank=0, line_start=0, frame_start=0, hs=1, vs=1.
- State machine:
  - States: IDLE (running=0) and RUN.
  - The first posedge after reset_n deasserts moves IDLE->RUN. Counters stay at 0 on that edge.
  - In the first RUN cycle DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1.
- Counting, each posedge in RUN:
  - h_cnt increments.
  - When h_cnt==H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt==V_TOTAL-1 at that same wrap, v_cnt wraps to 0 and frame_count increments (modulo 2^16).
- DrawX/DrawY are the registered counters (zero-extended to 10 bits).
- blank, line_start and frame_start are combinational decodes of the registered counters, gated by running.
- Raw sync, before delay:
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- Delay: hs, vs, blank_d equal {hs_raw, vs_raw, blank} from OUT_DELAY cycles earlier. With OUT_DELAY=0 they are combinational pass-through.
- Latency: DrawX/DrawY/blank have 0 cycles from counter; hs/vs/blank_d have OUT_DELAY cycles.
- Reset mid-frame: everything returns to IDLE immediately. The next frame restarts at (0,0) with no partial sync pulse from the pipeline.
- Parameter check: elaboration error if H_TOTAL>1024, V_TOTAL>1024, or OUT_DELAY>4.

Decomposition:
- vga_timing_pkg:
  - 640x480@60 default constants: H_VISIBLE..V_BACK, H_TOTAL=800, V_TOTAL=525.
  - localparam widths COORD_W=10, FRAME_W=16.
  - typedef struct vga_sync_t {hs, vs, blank}.
- Sub-module vga_sync_delay: parameterised shift register of vga_sync_t with depth OUT_DELAY, async active-low reset to idle {1,1,0}.

Test Plan:
- Reset release: hold reset_n=0 for 5 clocks, then release -> outputs idle during reset; first RUN cycle has DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1.
- Line timing: run one line -> blank=1 exactly for DrawX 0..639; hs=0 for exactly 96 clocks; hs falls OUT_DELAY=1 clock after DrawX==656; DrawX wraps 799->0 with DrawY 0->1.
- Frame timing: run one frame (420000 clocks) -> vs=0 for exactly 1600 clocks; vs falls 1 clock after (DrawX=0, DrawY=490); frame_count 0->1 as DrawY wraps 524->0; exactly 525 line_start pulses and 1 frame_start pulse.
- blank_d alignment: compare blank_d with blank delayed by one cycle for a full frame -> identical every cycle; blank_d=1 count equals 307200.
- Mid-frame reset: assert reset_n=0 at DrawX=700, DrawY=491 (inside hs and vs) -> hs=vs=1 and blank_d=0 immediately (asynchronously); after release, the frame restarts at (0,0) and frame_count=0.
- Wrap and parameters: preload frame_count=65535 via force, complete one frame -> frame_count=0. Rebuild with OUT_DELAY=0 -> hs falls in the same cycle DrawX==656.
